// File: rtl/fir_symm_coef_filter.sv
// fir_symm_coef_filter
//   Receives the unique half of an even-symmetric FIR coefficient set into a
//   shadow bank. Once a complete set has arrived, the set is swapped into the
//   active bank. The sample stream is filtered by a single time-multiplexed
//   pre-add / multiply / accumulate datapath, at one output per 54 cycles.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   coef_load_en     load window (rise opens and clears bitmap, fall closes)
//   coef_valid       one strobe per coefficient write
//   coef_idx         unique-coefficient index 0..TAPS/2-1 (0 = outer pair)
//   coef_data        signed coefficient, COEF_SHIFT fractional bits
//   din_valid/din    input sample strobe and value
//   din_ready        high only while the MAC engine is idle
//   dout_valid/dout  one-cycle result pulse and held result
//   coef_ready       a complete coefficient set is active
//   overrun          sticky: a sample arrived while busy and was dropped
module fir_symm_coef_filter #(
  parameter int TAPS       = 100,
  parameter int COEF_SHIFT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coef_load_en,
  input  logic               coef_valid,
  input  logic [5:0]         coef_idx,
  input  logic signed [15:0] coef_data,
  input  logic               din_valid,
  input  logic signed [15:0] din,
  output logic               din_ready,
  output logic               dout_valid,
  output logic signed [15:0] dout,
  output logic               coef_ready,
  output logic               overrun
);

  localparam int NCOEF  = TAPS / 2;
  localparam int PW     = $clog2(TAPS);
  localparam int PROD_W = 33;
  localparam int ACC_W  = 40;
  localparam int STAGES = 1;

  localparam logic [5:0] LAST_K  = 6'(NCOEF - 1);
  localparam logic [5:0] NCOEF_6 = 6'(NCOEF);

  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(2 ** (COEF_SHIFT - 1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W+1)'(-32768);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t state_q, state_d;

  logic [5:0]               k_q;
  logic                     drn_q;
  logic [PW-1:0]            wp, pa, pb;
  logic signed [15:0]       dly [TAPS];
  logic signed [15:0]       shadow [NCOEF];
  logic signed [15:0]       active [NCOEF];
  logic [NCOEF-1:0]         bitmap, bm_wr;
  logic                     swap_pending, load_d;

  // vld_pipe[0]: pre_r/coef_r hold a live term, vld_pipe[1]: prod_r does
  logic [STAGES:0]          vld_pipe;
  logic signed [16:0]       pre_r;
  logic signed [15:0]       coef_r;
  logic signed [PROD_W-1:0] prod_r;
  logic signed [ACC_W-1:0]  acc;

  logic               accept, mac_issue, swap_do, coef_wr, load_rise, load_fall;
  logic signed [ACC_W:0] rnd, shf;
  logic signed [15:0] sat_val;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TAPS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(TAPS - 1) : p - 1'b1;
  endfunction

  assign din_ready = (state_q == S_IDLE);
  assign accept    = din_valid && din_ready;
  assign mac_issue = (state_q == S_MAC);
  // A pending swap only lands while idle, so it never disturbs a running sum.
  assign swap_do   = swap_pending && (state_q == S_IDLE);
  assign load_rise = coef_load_en && !load_d;
  assign load_fall = !coef_load_en && load_d;
  assign coef_wr   = coef_valid && coef_load_en && (coef_idx < NCOEF_6);
  assign bm_wr     = coef_wr ? (NCOEF'(1) << coef_idx) : '0;

  // Round half up, arithmetic shift, then clamp to the 16-bit range.
  always_comb begin
    rnd = {acc[ACC_W-1], acc} + RND_HALF;
    shf = rnd >>> COEF_SHIFT;
    if (shf > SAT_MAX)      sat_val = 16'sh7fff;
    else if (shf < SAT_MIN) sat_val = 16'sh8000;
    else                    sat_val = shf[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (din_valid)       state_d = S_MAC;
      S_MAC:   if (k_q == LAST_K)   state_d = S_DRAIN;
      S_DRAIN: if (drn_q)           state_d = S_OUT;
      S_OUT:                        state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Delay line plus MAC datapath. pa walks back from the newest sample,
  // pb walks forward from the oldest, so each cycle pairs x[n-k] with
  // x[n-(TAPS-1)+k].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) dly[i] <= '0;
      wp         <= '0;
      pa         <= '0;
      pb         <= '0;
      k_q        <= '0;
      drn_q      <= 1'b0;
      vld_pipe   <= '0;
      pre_r      <= '0;
      coef_r     <= '0;
      prod_r     <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      drn_q    <= (state_q == S_DRAIN) ? !drn_q : 1'b0;
      vld_pipe <= {vld_pipe[STAGES-1:0], mac_issue};

      if (accept) begin
        dly[wp] <= din;
        wp      <= ptr_inc(wp);
        pa      <= wp;
        pb      <= ptr_inc(wp);
        k_q     <= '0;
        acc     <= '0;
      end else begin
        if (mac_issue) begin
          pa  <= ptr_dec(pa);
          pb  <= ptr_inc(pb);
          k_q <= k_q + 1'b1;
        end
        if (vld_pipe[1])
          acc <= acc + {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
      end

      if (mac_issue) begin
        pre_r  <= {dly[pa][15], dly[pa]} + {dly[pb][15], dly[pb]};
        coef_r <= active[k_q];
      end
      if (vld_pipe[0]) prod_r <= pre_r * coef_r;

      dout_valid <= (state_q == S_OUT);
      if (state_q == S_OUT) dout <= sat_val;

      if (din_valid && !din_ready) overrun <= 1'b1;
    end
  end

  // Coefficient capture and bank swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      bitmap       <= '0;
      swap_pending <= 1'b0;
      load_d       <= 1'b0;
      coef_ready   <= 1'b0;
    end else begin
      load_d <= coef_load_en;
      if (coef_wr) shadow[coef_idx] <= coef_data;
      // A write on the opening edge still counts toward the new set.
      bitmap <= (load_rise ? '0 : bitmap) | bm_wr;

      if (swap_do) begin
        for (int i = 0; i < NCOEF; i++) active[i] <= shadow[i];
        coef_ready   <= 1'b1;
        swap_pending <= 1'b0;
      end
      // Incomplete sets are simply never promoted.
      if (load_fall && (&bitmap)) swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_symm_coef_filter.sv
// Directed bench for fir_symm_coef_filter with a scoreboard: the expected
// output of every accepted sample is computed from a full-length direct-form
// convolution model and queued; each dout_valid pulse pops and compares.
module tb_fir_symm_coef_filter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               coef_load_en, coef_valid, din_valid;
  logic [5:0]         coef_idx;
  logic signed [15:0] coef_data, din;
  logic               din_ready, dout_valid, coef_ready, overrun;
  logic signed [15:0] dout;

  fir_symm_coef_filter #(.TAPS(100), .COEF_SHIFT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .coef_load_en(coef_load_en), .coef_valid(coef_valid),
    .coef_idx(coef_idx), .coef_data(coef_data),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout(dout),
    .coef_ready(coef_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int dv_count = 0, last_dv_cyc = 0, acc_cyc = 0;
  int q[$];
  int hist[100];
  int act[50];
  int newc[50];

  // Reference: plain 100-tap convolution with the symmetric set expanded.
  function automatic int model_out();
    longint s = 0;
    for (int i = 0; i < 100; i++) begin
      int ci = (i < 50) ? i : 99 - i;
      s += longint'(act[ci]) * longint'(hist[i]);
    end
    s = (s + 64'sd16384) >>> 15;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic push_model(input int x);
    for (int i = 99; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    q.push_back(model_out());
  endtask

  task automatic model_reset();
    for (int i = 0; i < 100; i++) hist[i] = 0;
    for (int i = 0; i < 50; i++) act[i] = 0;
    q.delete();
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  // Every clock of the run passes through here, so no output pulse is missed.
  task automatic tick();
    logic signed [31:0] got;
    int e;
    @(negedge clk);
    cyc++;
    if (dout_valid === 1'b1) begin
      dv_count++;
      last_dv_cyc = cyc;
      got = dout;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL dout_unexpected: got %0d, required no pulse", got);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert (got === e) else begin
          errors++;
          $error("FAIL dout_sample: got %0d, required %0d", got, e);
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (din_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    assert (din_ready === 1'b1) else begin
      errors++;
      $error("FAIL ready_timeout: got din_ready=%b, required 1", din_ready);
    end
  endtask

  task automatic send(input int x);
    wait_ready();
    din       = 16'(x);
    din_valid = 1'b1;
    @(posedge clk);
    push_model(x);
    tick();
    din_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic open_write(input int n, input bit bad_idx);
    coef_load_en = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      coef_idx   = 6'(i);
      coef_data  = 16'(newc[i]);
      coef_valid = 1'b1;
      tick();
      coef_valid = 1'b0;
    end
    if (bad_idx) begin
      coef_idx   = 6'd50;
      coef_data  = 16'sh1234;
      coef_valid = 1'b1;
      tick();
      coef_valid = 1'b0;
    end
  endtask

  task automatic close_load();
    coef_load_en = 1'b0;
    tick();
  endtask

  initial begin
    int dv0;
    rst_n = 1'b0; coef_load_en = 1'b0; coef_valid = 1'b0; din_valid = 1'b0;
    coef_idx = '0; coef_data = '0; din = '0;
    model_reset();
    repeat (3) tick();
    check("rst_din_ready",  din_ready,  1);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout",       dout,       0);
    check("rst_coef_ready", coef_ready, 0);
    check("rst_overrun",    overrun,    0);
    rst_n = 1'b1;
    tick();

    // Impulse through a single outer-pair coefficient of 0.5.
    for (int i = 0; i < 50; i++) newc[i] = 0;
    newc[0] = 16384;
    open_write(50, 1'b0);
    close_load();
    check("swap_not_yet", coef_ready, 0);
    tick();
    check("swap_coef_ready", coef_ready, 1);
    act = newc;
    send(1000);
    check("busy_after_accept", din_ready, 0);
    wait_ready();
    check("impulse_head", dout, 500);
    for (int i = 0; i < 99; i++) send(0);
    wait_ready();
    check("impulse_tail", dout, 500);

    // Incomplete set plus an out-of-range index: bank must not change.
    for (int i = 0; i < 50; i++) newc[i] = 9999;
    open_write(49, 1'b1);
    close_load();
    repeat (3) tick();
    check("incomplete_coef_ready", coef_ready, 1);
    send(1000);
    wait_ready();
    check("incomplete_keeps_bank", dout, 500);
    send(0);

    // Close a complete load while a sample is mid-MAC.
    for (int i = 0; i < 50; i++) newc[i] = ((i * 37) % 500) - 200;
    newc[0] = 8192;
    open_write(50, 1'b0);
    send(2000);
    repeat (5) tick();
    close_load();
    act = newc;
    check("deferred_coef_ready", coef_ready, 1);
    send(300);
    send(-400);
    send(0);
    wait_ready();

    // Saturation at both rails.
    for (int i = 0; i < 50; i++) newc[i] = 32767;
    open_write(50, 1'b0);
    close_load();
    repeat (2) tick();
    act = newc;
    for (int i = 0; i < 105; i++) send(32767);
    wait_ready();
    check("sat_pos", dout, 32767);
    for (int i = 0; i < 105; i++) send(-32768);
    wait_ready();
    check("sat_neg", dout, -32768);

    // Overrun: second strobe at edge 5 is dropped.
    check("overrun_clear", overrun, 0);
    dv0 = dv_count;
    send(1234);
    repeat (4) tick();
    din = 16'sd777;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("overrun_set", overrun, 1);
    wait_ready();
    check("overrun_one_pulse", dv_count - dv0, 1);
    check("dout_latency", last_dv_cyc - acc_cyc, 53);

    // Reset in the middle of a MAC.
    send(5000);
    repeat (19) tick();
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    check("midrst_dout_valid", dout_valid, 0);
    rst_n = 1'b1;
    repeat (60) tick();
    check("midrst_din_ready",  din_ready,  1);
    check("midrst_coef_ready", coef_ready, 0);
    check("midrst_dout",       dout,       0);
    check("midrst_overrun",    overrun,    0);
    send(500);
    wait_ready();
    check("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_symm_coef_filter.md
# fir_symm_coef_filter

Coefficient-consuming end of the window-method FIR coefficient stream. The block captures the 50 unique coefficients of a 100-tap even-symmetric low-pass filter into a shadow bank and swaps them atomically into an active bank once a complete set has arrived. It then filters a 16-bit sample stream with a time-multiplexed, symmetric pre-add MAC. It sits between the coefficient generator and the downstream FIFO/output path.

## Interface
Parameters:
- `TAPS`, 100: filter length. Must be even; unique coefficients = TAPS/2 = 50.
- `COEF_SHIFT`, 15: fractional bits of the coefficient format; also the output right-shift.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `coef_load_en`, in, 1: load window. Its rising edge opens a load and its falling edge closes it.
- `coef_valid`, in, 1: one-cycle strobe, one per coefficient.
- `coef_idx`, in, 6: coefficient index 0..49. Index 0 is the outer pair h[0]=h[99]; index 49 is the centre pair h[49]=h[50].
- `coef_data`, in, 16 signed: coefficient value.
- `din_valid`, in, 1: input sample strobe.
- `din`, in, 16 signed: input sample.
- `din_ready`, out, 1: high when a sample can be accepted. Reset value 1.
- `dout_valid`, out, 1: one-cycle pulse per output sample. Reset value 0.
- `dout`, out, 16 signed: filtered sample; holds its value between pulses. Reset value 0.
- `coef_ready`, out, 1: a complete coefficient set is active. Reset value 0.
- `overrun`, out, 1: sticky flag, set when a sample is dropped; cleared only by reset. Reset value 0.

## Operation
Coefficient load:
- The rising edge of `coef_load_en` clears the 50-bit received bitmap.
- A `coef_valid` strobe with `coef_load_en`=1 and `coef_idx`≤49 writes `coef_data` to `shadow[idx]` and sets `bitmap[idx]`.
- Strobes with idx>49, or with `coef_load_en`=0, are ignored.
- Rewriting an index is allowed; the last write wins.
- On the falling edge of `coef_load_en`:
  - If the bitmap is all ones, `swap_pending` is set.
  - Otherwise the set is discarded; the active bank and `coef_ready` are unchanged.
- The swap (active←shadow, `coef_ready`←1, `swap_pending`←0) executes only on a cycle where the MAC FSM is in S_IDLE. A pending swap therefore never alters an in-flight output.
- The active bank resets to all zeros, so `dout`=0 until the first swap.

Delay line:
- 100×16 circular buffer with a write pointer `wp` that wraps 99→0.
- An accepted sample is written at `wp`, then `wp` increments.
- Buffer and `wp` reset to 0.

MAC FSM:
- **S_IDLE**: `din_ready`=1. On `din_valid`, store the sample and go to S_MAC with k=0.
- **S_MAC**, 50 cycles (k=0..49):
  - pre = x[n−k] + x[n−99+k], 17-bit signed.
  - prod = pre × active[k], 33-bit.
  - Pre-add and multiply are each registered, forming a 2-stage pipe.
  - acc is 40-bit signed and is cleared on S_IDLE→S_MAC.
- **S_DRAIN**, 2 cycles: flush the pipe into acc.
- **S_OUT**, 1 cycle:
  - Compute (acc + 2^(COEF_SHIFT−1)) >>> COEF_SHIFT.
  - Saturate the result to [−32768, 32767], register it to `dout`, pulse `dout_valid`.
  - Return to S_IDLE.
- `din_ready`=0 in all states except S_IDLE.
- `din_valid` while `din_ready`=0 drops the sample and sets `overrun`.

Reset mid-operation: FSM→S_IDLE, acc, bitmap and `swap_pending` cleared, all outputs at their reset values, active bank zeroed.

## Timing
- Accept edge = edge 0 (`din_valid`&`din_ready`). `din_ready` is low from the cycle after edge 0.
- `dout_valid` is high for exactly the one cycle following edge 53. `dout` updates on that same edge.
- `din_ready` returns high in the cycle following edge 53, so a new sample can be accepted at edge 54.
- Maximum throughput is 1 sample per 54 cycles.
- Swap:
  - If the FSM is idle at the falling-edge cycle, the swap happens on the next edge and `coef_ready` rises 1 cycle after the `coef_load_en` fall is sampled.
  - Otherwise the swap is deferred to the first S_IDLE cycle. In that cycle the swap takes precedence: a sample accepted on the same edge already uses the new bank.
- A `coef_valid` coinciding with the closing edge of `coef_load_en` (`coef_load_en` already 0) is ignored.

## Test plan
- **Impulse:** load idx0=16384, all others 0; din=1000 followed by 99 zeros → outputs 500 at samples 0 and 99, 0 elsewhere; `coef_ready`=1.
- **Saturation:** load all 50 coefficients = 32767; drive constant din=32767 → steady-state `dout`=32767; constant −32768 → `dout`=−32768.
- **Incomplete load:** after a valid set, open a load, write idx 0..48 only, close → `coef_ready` stays 1 and impulse response is unchanged. A strobe with idx=50 has no effect.
- **Deferred swap:** close a complete load while the FSM is in S_MAC → the current `dout` uses the old bank; the next sample uses the new bank.
- **Overrun:** `din_valid` at edges 0 and 5 → second sample dropped, `overrun`=1, exactly one `dout_valid` pulse, at the cycle after edge 53.
- **Reset mid-MAC:** assert `rst_n`=0 at edge 20 → no `dout_valid`; `din_ready`=1, `coef_ready`=0, `dout`=0 after release.
